// File: rtl/vec_wb_stage.sv
// Elastic MEM/WB stage with a 2-entry skid buffer, synchronous flush and per-lane write masking.
// Optional backpressure counter on stall_cnt is built when VWB_STALL_CNT_EN is defined.
module vec_wb_stage #(
    parameter int N     = 20,
    parameter int LANES = 8,
    parameter int AW    = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [LANES*N-1:0]   in_rd,
    input  logic [LANES*N-1:0]   in_alu,
    input  logic [AW-1:0]        in_wa3,
    input  logic                 in_regwrite,
    input  logic                 in_memtoreg,
    input  logic [LANES-1:0]     in_mask,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [LANES*N-1:0]   out_rd,
    output logic [LANES*N-1:0]   out_alu,
    output logic [AW-1:0]        out_wa3,
    output logic                 out_regwrite,
    output logic                 out_memtoreg,
    output logic [LANES-1:0]     out_mask
`ifdef VWB_STALL_CNT_EN
    ,
    output logic [15:0]          stall_cnt
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t                state_q;
    logic [LANES*N-1:0]    main_rd_q, main_alu_q, skid_rd_q, skid_alu_q;
    logic [AW-1:0]         main_wa3_q, skid_wa3_q;
    logic                  main_rw_q, main_m2r_q, skid_rw_q, skid_m2r_q;
    logic [LANES-1:0]      main_mask_q, skid_mask_q;
    logic [LANES*N-1:0]    cap_rd_d, cap_alu_d;
    logic                  accept_s, consume_s;

    function automatic logic [LANES*N-1:0] apply_mask(input logic [LANES*N-1:0] data,
                                                      input logic [LANES-1:0]   mask);
        logic [LANES*N-1:0] res;
        res = {(LANES*N){1'b0}};
        for (int i = 0; i < LANES; i++) begin
            if (mask[i]) begin
                res[i*N +: N] = data[i*N +: N];
            end else begin
                res[i*N +: N] = {N{1'b0}};
            end
        end
        return res;
    endfunction

    assign in_ready     = (state_q != FULL);
    assign out_valid    = (state_q != EMPTY);
    assign accept_s     = in_valid && in_ready;
    assign consume_s    = out_valid && out_ready;
    assign cap_rd_d     = apply_mask(in_rd, in_mask);
    assign cap_alu_d    = apply_mask(in_alu, in_mask);
    assign out_rd       = main_rd_q;
    assign out_alu      = main_alu_q;
    assign out_wa3      = main_wa3_q;
    assign out_regwrite = main_rw_q && out_valid;
    assign out_memtoreg = main_m2r_q;
    assign out_mask     = main_mask_q;

    // Occupancy FSM with main/skid storage; flush drops entries but keeps stale data.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= EMPTY;
            main_rd_q   <= {(LANES*N){1'b0}};
            main_alu_q  <= {(LANES*N){1'b0}};
            main_wa3_q  <= {AW{1'b0}};
            main_rw_q   <= 1'b0;
            main_m2r_q  <= 1'b0;
            main_mask_q <= {LANES{1'b0}};
            skid_rd_q   <= {(LANES*N){1'b0}};
            skid_alu_q  <= {(LANES*N){1'b0}};
            skid_wa3_q  <= {AW{1'b0}};
            skid_rw_q   <= 1'b0;
            skid_m2r_q  <= 1'b0;
            skid_mask_q <= {LANES{1'b0}};
        end else if (flush) begin
            state_q <= EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept_s) begin
                        main_rd_q   <= cap_rd_d;
                        main_alu_q  <= cap_alu_d;
                        main_wa3_q  <= in_wa3;
                        main_rw_q   <= in_regwrite;
                        main_m2r_q  <= in_memtoreg;
                        main_mask_q <= in_mask;
                        state_q     <= ONE;
                    end
                end
                ONE: begin
                    if (accept_s && consume_s) begin
                        main_rd_q   <= cap_rd_d;
                        main_alu_q  <= cap_alu_d;
                        main_wa3_q  <= in_wa3;
                        main_rw_q   <= in_regwrite;
                        main_m2r_q  <= in_memtoreg;
                        main_mask_q <= in_mask;
                    end else if (accept_s) begin
                        skid_rd_q   <= cap_rd_d;
                        skid_alu_q  <= cap_alu_d;
                        skid_wa3_q  <= in_wa3;
                        skid_rw_q   <= in_regwrite;
                        skid_m2r_q  <= in_memtoreg;
                        skid_mask_q <= in_mask;
                        state_q     <= FULL;
                    end else if (consume_s) begin
                        state_q <= EMPTY;
                    end
                end
                FULL: begin
                    if (consume_s) begin
                        main_rd_q   <= skid_rd_q;
                        main_alu_q  <= skid_alu_q;
                        main_wa3_q  <= skid_wa3_q;
                        main_rw_q   <= skid_rw_q;
                        main_m2r_q  <= skid_m2r_q;
                        main_mask_q <= skid_mask_q;
                        state_q     <= ONE;
                    end
                end
                default: begin
                    state_q <= EMPTY;
                end
            endcase
        end
    end

`ifdef VWB_STALL_CNT_EN
    logic [15:0] stall_cnt_q;

    // Saturating count of cycles where a valid output is held off; only reset clears it.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= 16'h0000;
        end else if (out_valid && !out_ready && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'h0001;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_vec_wb_stage.sv
// Directed self-checking bench for vec_wb_stage; counter test is built with VWB_STALL_CNT_EN.
module tb_vec_wb_stage;
    localparam int N     = 20;
    localparam int LANES = 8;
    localparam int AW    = 4;

    logic                clk = 1'b0;
    logic                reset, flush, in_valid, in_ready;
    logic [LANES*N-1:0]  in_rd, in_alu, out_rd, out_alu;
    logic [AW-1:0]       in_wa3, out_wa3;
    logic                in_regwrite, in_memtoreg, out_valid, out_ready;
    logic                out_regwrite, out_memtoreg;
    logic [LANES-1:0]    in_mask, out_mask;
`ifdef VWB_STALL_CNT_EN
    logic [15:0]         stall_cnt;
`endif

    int vectors    = 0;
    int miscompares = 0;

    vec_wb_stage #(.N(N), .LANES(LANES), .AW(AW)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rd(in_rd), .in_alu(in_alu), .in_wa3(in_wa3),
        .in_regwrite(in_regwrite), .in_memtoreg(in_memtoreg), .in_mask(in_mask),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_rd(out_rd), .out_alu(out_alu), .out_wa3(out_wa3),
        .out_regwrite(out_regwrite), .out_memtoreg(out_memtoreg), .out_mask(out_mask)
`ifdef VWB_STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        in_rd = {LANES{20'h11111}}; in_alu = {LANES{20'h22222}};
        in_wa3 = 4'd5; in_regwrite = 1'b1; in_memtoreg = 1'b1; in_mask = 8'hFF;
        step(); step();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b want 0", out_valid); end
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready got %b want 1", in_ready); end
        vectors++; if (out_alu !== {(LANES*N){1'b0}}) begin miscompares++; $display("FAIL reset_alu got %h want 0", out_alu); end
        vectors++; if (out_mask !== 8'h00 || out_regwrite !== 1'b0 || out_wa3 !== 4'd0) begin
            miscompares++; $display("FAIL reset_ctrl got mask=%h rw=%b wa3=%0d want 0/0/0", out_mask, out_regwrite, out_wa3); end
`ifdef VWB_STALL_CNT_EN
        vectors++; if (stall_cnt !== 16'h0000) begin miscompares++; $display("FAIL reset_stall got %h want 0", stall_cnt); end
`endif
        in_valid = 1'b0;
        reset = 1'b0;
    endtask

    task automatic test_stream();
        logic [N-1:0] lane;
        out_ready = 1'b1; in_mask = 8'hFF; in_regwrite = 1'b1; in_memtoreg = 1'b0;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_wa3 = AW'(i);
            lane = 20'h00100 + N'(i);
            in_alu = {LANES{lane}};
            step();
            vectors++; if (out_valid !== 1'b1 || out_wa3 !== AW'(i) || out_regwrite !== 1'b1) begin
                miscompares++; $display("FAIL stream_%0d got v=%b wa3=%0d rw=%b want 1/%0d/1", i, out_valid, out_wa3, out_regwrite, i); end
            vectors++; if (out_alu !== {LANES{lane}} || in_ready !== 1'b1) begin
                miscompares++; $display("FAIL stream_data_%0d got %h rdy=%b want %h rdy=1", i, out_alu, in_ready, {LANES{lane}}); end
        end
        in_valid = 1'b0;
        step();
        vectors++; if (out_valid !== 1'b0 || out_regwrite !== 1'b0) begin
            miscompares++; $display("FAIL stream_drain got v=%b rw=%b want 0/0", out_valid, out_regwrite); end
    endtask

    task automatic test_skid();
        out_ready = 1'b1; in_valid = 1'b1; in_wa3 = 4'd3;
        step();
        vectors++; if (out_wa3 !== 4'd3 || out_valid !== 1'b1) begin
            miscompares++; $display("FAIL skid_first got wa3=%0d v=%b want 3/1", out_wa3, out_valid); end
        out_ready = 1'b0; in_wa3 = 4'd4;
        step();
        vectors++; if (in_ready !== 1'b0 || out_wa3 !== 4'd3) begin
            miscompares++; $display("FAIL skid_full got rdy=%b wa3=%0d want 0/3", in_ready, out_wa3); end
        in_valid = 1'b0;
        step();
        vectors++; if (out_wa3 !== 4'd3 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
            miscompares++; $display("FAIL skid_hold got wa3=%0d v=%b rdy=%b want 3/1/0", out_wa3, out_valid, in_ready); end
        out_ready = 1'b1;
        step();
        vectors++; if (out_wa3 !== 4'd4 || out_valid !== 1'b1 || in_ready !== 1'b1) begin
            miscompares++; $display("FAIL skid_second got wa3=%0d v=%b rdy=%b want 4/1/1", out_wa3, out_valid, in_ready); end
        step();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL skid_empty got v=%b want 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1; in_valid = 1'b1; in_wa3 = 4'd10;
        step();
        out_ready = 1'b0; in_wa3 = 4'd11;
        step();
        out_ready = 1'b1; in_wa3 = 4'd12;
        step();
        vectors++; if (out_wa3 !== 4'd11 || in_ready !== 1'b1) begin
            miscompares++; $display("FAIL b2b_drain got wa3=%0d rdy=%b want 11/1", out_wa3, in_ready); end
        step();
        vectors++; if (out_wa3 !== 4'd12 || out_valid !== 1'b1) begin
            miscompares++; $display("FAIL b2b_next got wa3=%0d v=%b want 12/1", out_wa3, out_valid); end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_flush();
        out_ready = 1'b0; in_valid = 1'b1; in_wa3 = 4'd5;
        step();
        in_wa3 = 4'd6;
        step();
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL flush_setup got rdy=%b want 0", in_ready); end
        flush = 1'b1; in_wa3 = 4'd9;
        step();
        vectors++; if (out_valid !== 1'b0 || out_regwrite !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++; $display("FAIL flush_drop got v=%b rw=%b rdy=%b want 0/0/1", out_valid, out_regwrite, in_ready); end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++; if (out_valid !== 1'b0) begin
                miscompares++; $display("FAIL flush_ghost_%0d got v=%b wa3=%0d want v=0", i, out_valid, out_wa3); end
        end
    endtask

    task automatic test_mask();
        logic [LANES*N-1:0] exp_alu, exp_rd;
        exp_alu = {20'hABCDE, 20'h00000, 20'hABCDE, 20'h00000, 20'h00000, 20'hABCDE, 20'h00000, 20'hABCDE};
        exp_rd  = {20'h12345, 20'h00000, 20'h12345, 20'h00000, 20'h00000, 20'h12345, 20'h00000, 20'h12345};
        out_ready = 1'b1; in_valid = 1'b1; in_wa3 = 4'd7; in_memtoreg = 1'b1; in_regwrite = 1'b1;
        in_alu = {LANES{20'hABCDE}}; in_rd = {LANES{20'h12345}}; in_mask = 8'b1010_0101;
        step();
        vectors++; if (out_alu !== exp_alu) begin miscompares++; $display("FAIL mask_alu got %h want %h", out_alu, exp_alu); end
        vectors++; if (out_rd !== exp_rd) begin miscompares++; $display("FAIL mask_rd got %h want %h", out_rd, exp_rd); end
        vectors++; if (out_mask !== 8'hA5 || out_memtoreg !== 1'b1) begin
            miscompares++; $display("FAIL mask_ctrl got mask=%h m2r=%b want a5/1", out_mask, out_memtoreg); end
        in_valid = 1'b0; in_mask = 8'hFF;
        step();
    endtask

`ifdef VWB_STALL_CNT_EN
    task automatic test_counter();
        out_ready = 1'b0; in_valid = 1'b1; in_wa3 = 4'd1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 70000; i++) @(posedge clk);
        #1;
        vectors++; if (stall_cnt !== 16'hFFFF) begin miscompares++; $display("FAIL stall_sat got %h want ffff", stall_cnt); end
        flush = 1'b1;
        step();
        flush = 1'b0;
        step();
        vectors++; if (stall_cnt !== 16'hFFFF || out_valid !== 1'b0) begin
            miscompares++; $display("FAIL stall_flush got %h v=%b want ffff/0", stall_cnt, out_valid); end
    endtask
`endif

    initial begin
        test_reset();
        test_stream();
        test_skid();
        test_back_to_back();
        test_flush();
        test_mask();
`ifdef VWB_STALL_CNT_EN
        test_counter();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
